uart_cmd_parser: RTL

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser_pkg.sv | 20 ++
 rtl/uart_cmd_parser_cmd_buf.sv | 27 ++
 rtl/uart_cmd_parser.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command frame parser: FSM states, error
// codes and the default start-of-frame byte.
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_EMIT    = 3'd4
  } state_e;

  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0]  SOF_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/uart_cmd_parser_cmd_buf.sv
// Payload staging buffer: register array with synchronous write and
// combinational read; storage is intentionally not reset.
module cmd_buf #(
  parameter int unsigned nbits = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [nbits-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [nbits-1:0] rdata_o
);

  logic [nbits-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Out-of-range reads only happen one past the last byte and are never used.
  assign rdata_o = (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/uart_cmd_parser.sv
// Pulls bytes from a receive FIFO, validates SOF/LEN/payload/CSUM frames and
// replays good payloads on a valid/ready stream.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned      nbits   = 8,
  parameter int unsigned      MAX_LEN = 16,
  parameter logic [nbits-1:0] SOF     = nbits'(SOF_DEFAULT),
  parameter int unsigned      TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_empty,
  input  logic [nbits-1:0]       rx_data,
  output logic                   rx_rd_en,
  output logic [nbits-1:0]       pl_data,
  output logic                   pl_valid,
  output logic                   pl_last,
  input  logic                   pl_ready,
  output logic                   frm_err,
  output logic [1:0]             err_code,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e                 state_q, state_d;
  logic [nbits-1:0]       len_q, len_d;
  logic [nbits-1:0]       sum_q, sum_d;
  logic [nbits-1:0]       idx_q, idx_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   rd_en_q, rd_en_d;
  logic [nbits-1:0]       pl_data_q, pl_data_d;
  logic                   pl_valid_q, pl_valid_d;
  logic                   pl_last_q, pl_last_d;
  logic                   frm_err_q, frm_err_d;
  logic [1:0]             err_code_q, err_code_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic                   take_c;
  logic                   wr_en_c;
  logic [nbits-1:0]       nxt_idx_c;
  logic [nbits-1:0]       rd_byte_c;
  logic [nbits-1:0]       sum_add_c;
  logic [TW-1:0]          tmo_inc_c;

  assign take_c    = rd_en_q & ~rx_empty;
  assign wr_en_c   = take_c && (state_q == ST_PAYLOAD);
  assign sum_add_c = sum_q + rx_data;
  assign tmo_inc_c = tmo_q + TW'(1);
  // Read address looks one byte ahead so the next payload byte is ready on accept.
  assign nxt_idx_c = (state_q == ST_EMIT) ? idx_q + nbits'(1) : '0;

  cmd_buf #(
    .nbits (nbits),
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_cmd_buf (
    .clk     (clk),
    .we_i    (wr_en_c),
    .waddr_i (AW'(idx_q)),
    .wdata_i (rx_data),
    .raddr_i (AW'(nxt_idx_c)),
    .rdata_o (rd_byte_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    tmo_d       = '0;
    pl_data_d   = pl_data_q;
    pl_valid_d  = pl_valid_q;
    pl_last_d   = pl_last_q;
    frm_err_d   = 1'b0;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (take_c && (rx_data == SOF)) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (take_c) begin
          if ((rx_data == '0) || (32'(rx_data) > MAX_LEN)) begin
            frm_err_d  = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            len_d   = rx_data;
            sum_d   = rx_data;
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (take_c) begin
          sum_d = sum_add_c;
          idx_d = idx_q + nbits'(1);
          if (idx_d == len_q) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (take_c) begin
          if (sum_add_c == '0) begin
            state_d    = ST_EMIT;
            idx_d      = '0;
            pl_valid_d = 1'b1;
            pl_data_d  = rd_byte_c;
            pl_last_d  = (len_q == nbits'(1));
          end else begin
            frm_err_d  = 1'b1;
            err_code_d = ERR_CSUM;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_EMIT: begin
        if (pl_valid_q && pl_ready) begin
          if (pl_last_q) begin
            pl_valid_d  = 1'b0;
            pl_last_d   = 1'b0;
            idx_d       = '0;
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            state_d     = ST_IDLE;
          end else begin
            idx_d     = nxt_idx_c;
            pl_data_d = rd_byte_c;
            pl_last_d = (nxt_idx_c == len_q - nbits'(1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Inter-byte watchdog while a frame is being collected.
    if (((state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM)) && !take_c) begin
      if (tmo_inc_c == TW'(TIMEOUT)) begin
        frm_err_d  = 1'b1;
        err_code_d = ERR_TMO;
        state_d    = ST_IDLE;
      end else begin
        tmo_d = tmo_inc_c;
      end
    end

    rd_en_d = ~rx_empty & ~rd_en_q & (state_d != ST_EMIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      rd_en_q     <= 1'b0;
      pl_data_q   <= '0;
      pl_valid_q  <= 1'b0;
      pl_last_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      err_code_q  <= 2'b00;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      rd_en_q     <= rd_en_d;
      pl_data_q   <= pl_data_d;
      pl_valid_q  <= pl_valid_d;
      pl_last_q   <= pl_last_d;
      frm_err_q   <= frm_err_d;
      err_code_q  <= err_code_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign rx_rd_en  = rd_en_q;
  assign pl_data   = pl_data_q;
  assign pl_valid  = pl_valid_q;
  assign pl_last   = pl_last_q;
  assign frm_err   = frm_err_q;
  assign err_code  = err_code_q;
  assign frame_cnt = frame_cnt_q;

endmodule
